// File: rtl/program_counter_low_pkg.sv
// Shared types and defaults for the ADL consumer block (PCL, ABL, reset-vector sequencer).
// No logic here; constants and the sequencer state encoding only.
// Imported by program_counter_low and low_byte_incrementer.
package program_counter_low_pkg;

  // Default datapath width of ADL, PCL and ABL.
  localparam int PCL_WIDTH_DEF = 8;

  // Low bytes of the two reset-vector fetch addresses.
  localparam logic [7:0] VEC_LO_DEF = 8'hFC;
  localparam logic [7:0] VEC_HI_DEF = 8'hFD;

  // Post-reset sequencer: two vector-fetch cycles, then normal operation.
  typedef enum logic [1:0] {
    VEC_L = 2'd0,
    VEC_H = 2'd1,
    RUN   = 2'd2
  } vec_state_e;

endpackage

// File: rtl/low_byte_incrementer.sv
// Combinational WIDTH-bit +1 with carry-out, shared by the INC and LOAD&INC paths.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows the operand continuously.
module low_byte_incrementer
  import program_counter_low_pkg::*;
#(
  parameter int WIDTH = PCL_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  // Widen by one bit so the wrap from all-ones shows up as the carry.
  assign {o_carry, o_sum} = {1'b0, i_operand} + (WIDTH+1)'(1);

endmodule

// File: rtl/program_counter_low.sv
// ADL consumer: PCL load/increment with registered carry to PCH, ABL address register,
// and post-reset vector sequencer. Latency: one cycle from controls to all registered outputs.
// No backpressure. Optional macro ADL_BYPASS_EN: in RUN, ABL_LOAD forwards ADL_IN to ABL_OUT same cycle.
module program_counter_low
  import program_counter_low_pkg::*;
#(
  parameter int             WIDTH  = PCL_WIDTH_DEF,
  parameter logic [WIDTH-1:0] VEC_LO = WIDTH'(VEC_LO_DEF),
  parameter logic [WIDTH-1:0] VEC_HI = WIDTH'(VEC_HI_DEF)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_adl_in,
  input  logic             i_pcl_load,
  input  logic             i_pcl_inc,
  input  logic             i_abl_load,
  output logic [WIDTH-1:0] o_pcl_out,
  output logic             o_pcl_carry,
  output logic [WIDTH-1:0] o_abl_out,
  output logic             o_vec_busy
);

  vec_state_e       r_state;
  logic             r_vec_busy;
  logic [WIDTH-1:0] r_abl;
  logic [WIDTH-1:0] r_pcl;
  logic             r_pcl_carry;

  logic [WIDTH-1:0] w_inc_operand;
  logic [WIDTH-1:0] w_inc_sum;
  logic             w_inc_carry;

  // LOAD&INC increments the bus value, INC alone increments PCL; one adder serves both.
  assign w_inc_operand = i_pcl_load ? i_adl_in : r_pcl;

  low_byte_incrementer #(
    .WIDTH (WIDTH)
  ) u_inc (
    .i_operand (w_inc_operand),
    .o_sum     (w_inc_sum),
    .o_carry   (w_inc_carry)
  );

  // Vector sequencer: owns state, busy flag and the ABL register (vector states override loads).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= VEC_L;
      r_vec_busy <= 1'b1;
      r_abl      <= VEC_LO;
    end else begin
      case (r_state)
        VEC_L: begin
          r_state    <= VEC_H;
          r_vec_busy <= 1'b1;
          r_abl      <= VEC_HI;
        end
        VEC_H: begin
          // Busy drops on the same edge that enters RUN; ABL keeps the high vector address.
          r_state    <= RUN;
          r_vec_busy <= 1'b0;
          r_abl      <= VEC_HI;
        end
        RUN: begin
          r_state    <= RUN;
          r_vec_busy <= 1'b0;
          if (i_abl_load) begin
            r_abl <= i_adl_in;
          end
        end
        default: begin
          // Unreachable encoding: restart the vector sequence.
          r_state    <= VEC_L;
          r_vec_busy <= 1'b1;
          r_abl      <= VEC_LO;
        end
      endcase
    end
  end

  // PCL update and one-cycle carry pulse; active in every state so vector bytes can be loaded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pcl       <= '0;
      r_pcl_carry <= 1'b0;
    end else begin
      if (i_pcl_inc) begin
        r_pcl <= w_inc_sum;
      end else if (i_pcl_load) begin
        r_pcl <= i_adl_in;
      end
      // A load alone never carries; only a wrapping increment does.
      r_pcl_carry <= i_pcl_inc & w_inc_carry;
    end
  end

  assign o_pcl_out   = r_pcl;
  assign o_pcl_carry = r_pcl_carry;
  assign o_vec_busy  = r_vec_busy;

`ifdef ADL_BYPASS_EN
  // Forward the bus value straight to the pins while the register captures it.
  assign o_abl_out = ((r_state == RUN) && i_abl_load) ? i_adl_in : r_abl;
`else
  assign o_abl_out = r_abl;
`endif

endmodule

// File: doc/program_counter_low.md
Name: program_counter_low

Overview:
- Consumer end of the internal address bus low (ADL): the registers that capture the ADL bus value.
- Holds PCL, the low program-counter byte, with a load/increment path and a registered carry to the PCH block.
- Holds ABL, the external address-low output register.
- Contains a small post-reset sequencer that forces ABL to the reset-vector addresses before normal operation.

Parameters:
- WIDTH, 8, datapath width of ADL, PCL and ABL.
- VEC_LO, 8'hFC, low byte of the reset-vector low address.
- VEC_HI, 8'hFD, low byte of the reset-vector high address.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- ADL_IN  input  WIDTH  value on the internal address bus low.
- PCL_LOAD  input  1  capture ADL_IN into PCL.
- PCL_INC  input  1  increment PCL.
- ABL_LOAD  input  1  capture ADL_IN into ABL.
- PCL_OUT  output  WIDTH  current PCL (drives the PCL source input of the bus mux).
- PCL_CARRY  output  1  registered one-cycle pulse: PCL wrapped during the increment.
- ABL_OUT  output  WIDTH  external address bits [WIDTH-1:0].
- VEC_BUSY  output  1  high while the reset-vector sequence is active.

Behaviour:
- Reset (RST_N low, async): PCL_OUT=0, PCL_CARRY=0, ABL_OUT=VEC_LO, VEC_BUSY=1, state=VEC_L.
- FSM states: VEC_L, VEC_H, RUN.
  - VEC_L -> VEC_H on the first CLK edge after reset release.
  - VEC_H -> RUN on the next edge.
  - RUN is terminal until the next reset.
  - A reset mid-sequence or mid-RUN returns to VEC_L immediately.
- ABL register:
  - VEC_L: ABL_OUT=VEC_LO. VEC_H: ABL_OUT=VEC_HI. ABL_LOAD is ignored in both states.
  - RUN: if ABL_LOAD, ABL_OUT<=ADL_IN at the edge (visible the cycle after); otherwise hold.
- VEC_BUSY=1 in VEC_L and VEC_H; 0 in RUN. Registered; it falls in the same edge that enters RUN.
- PCL update (all states; the CPU loads fetched vector bytes through PCL_LOAD). At each edge:
  - PCL_LOAD & PCL_INC: PCL<=ADL_IN+1.
  - PCL_LOAD only: PCL<=ADL_IN.
  - PCL_INC only: PCL<=PCL+1.
  - Neither: hold.
  - Arithmetic is modulo 2^WIDTH.
- PCL_CARRY:
  - Set for exactly one cycle when the incremented operand was all-ones (PCL=FF for INC only; ADL_IN=FF for LOAD&INC).
  - Otherwise 0. Never set by a load alone.
- Latency: one cycle from control to PCL_OUT, ABL_OUT and PCL_CARRY.
- Controls are sampled only at CLK edges. X on a control that is low has no effect.

Optional Feature:
- Macro: ADL_BYPASS_EN.
- Defined: in RUN with ABL_LOAD=1, ABL_OUT = ADL_IN combinationally in the same cycle, and the register still captures at the edge. Vector states are unaffected.
- Undefined: ABL_OUT is purely registered, as described above.

Decomposition:
- Package program_counter_low_pkg holds:
  - the state encoding typedef (VEC_L=2'd0, VEC_H=2'd1, RUN=2'd2);
  - default VEC_LO/VEC_HI constants;
  - the WIDTH default.
- One sub-module, low_byte_incrementer: combinational WIDTH-bit +1 with carry-out, used for both the INC and LOAD&INC paths.

Test Plan:
1. Reset release then 3 idle clocks:
   - ABL_OUT = FC, FD, then held at FD.
   - VEC_BUSY = 1, 1, 0.
   - PCL_OUT = 00.
2. In RUN, PCL_LOAD with ADL_IN=FE, then PCL_INC twice:
   - PCL_OUT = FE, FF, 00.
   - PCL_CARRY pulses only on the cycle PCL_OUT=00.
3. PCL_LOAD&PCL_INC with ADL_IN=FF -> PCL_OUT=00, PCL_CARRY=1 for one cycle. With ADL_IN=12 -> PCL_OUT=13, PCL_CARRY=0.
4. ABL_LOAD with ADL_IN=5A:
   - During VEC_L: ABL_OUT stays FC/FD.
   - In RUN: ABL_OUT=5A the next cycle, and 5A the same cycle when ADL_BYPASS_EN is defined.
5. Assert RST_N low mid-cycle while PCL=37 and ABL=5A -> immediately PCL_OUT=00, ABL_OUT=FC, VEC_BUSY=1. The sequence restarts on release.
6. PCL_INC held 256 cycles from PCL=00 -> PCL_OUT returns to 00 with exactly one PCL_CARRY pulse.
